uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmit serializer between NUM_REQ byte-stream requesters.
//  Requesters are granted round-robin. A grant is held for a packet (req_last)
//    or for MAX_BURST bytes, whichever ends first.
//  Sequences the serializer over a tx_start/tx_done handshake, adds an
//    inter-frame gap, and aborts on a serializer watchdog timeout.
// PARAMETERS
//  NUM_REQ       4      number of requesters (2..8)
//  CLKS_PER_BIT  1250   clocks per UART bit; used as the GAP_CLKS default
//  GAP_CLKS      1250   idle clocks between frames (>=1)
//  MAX_BURST     4      max bytes per grant before a forced release (>=1)
//  TIMEOUT_CLKS  15000  max clocks from tx_start to tx_done
// PORTS
//  clock        in   1            system clock
//  reset        in   1            synchronous, active-low
//  req_valid    in   NUM_REQ      requester i has a byte; held high until req_ready[i]
//  req_data     in   8*NUM_REQ    byte of requester i in bits [8i+7:8i]
//  req_last     in   NUM_REQ      byte of requester i ends its packet
//  req_ready    out  NUM_REQ      one-cycle pulse: byte of requester i consumed
//  tx_start     out  1            one-cycle pulse to the serializer
//  tx_data      out  8            byte for the serializer; valid and held from tx_start until tx_done
//  tx_done      in   1            serializer finished the frame (one-cycle pulse)
//  grant_id     out  clog2(NUM_REQ)  current/last owner
//  grant_active out  1            a requester holds the lock
//  err_timeout  out  1            one-cycle pulse: watchdog expired
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE. Outputs: req_ready=0, tx_start=0,
//    tx_data=0, grant_active=0, err_timeout=0, grant_id=0.
//    last_grant=NUM_REQ-1, so requester 0 has first priority. All counters=0.
//  Reset mid-frame aborts immediately; no req_ready is issued for an in-flight byte.
//  States:
//    IDLE  if |req_valid: choose the first valid requester after last_grant
//          (wrapping). Set grant_id, grant_active=1, burst=0 -> SEND.
//    SEND  (1 cycle) tx_start=1, tx_data<=req_data[grant], req_ready[grant]=1.
//          Set burst+1. Set lock_end = req_last[grant] | (burst+1==MAX_BURST).
//          Clear the timer -> WAIT.
//    WAIT  the timer counts each cycle.
//          On tx_done -> GAP.
//          If the timer reaches TIMEOUT_CLKS-1 without tx_done: err_timeout=1,
//            lock_end=1 -> GAP.
//          tx_done and timeout in the same cycle: tx_done wins, no error.
//    GAP   count GAP_CLKS cycles, then:
//          !lock_end & req_valid[grant] -> SEND (same owner, no re-arbitration);
//          otherwise release: last_grant<=grant_id, grant_active=0 -> IDLE.
//          An owner not valid at the end of GAP loses the lock; no waiting.
//  Latency: req_valid rising in IDLE -> tx_start 2 cycles later.
//    Byte-to-byte spacing within a lock = serializer time + GAP_CLKS + 1.
//  Only one req_ready bit is ever high, and only in SEND.
//  tx_done outside WAIT is ignored.
//  Round-robin fairness: a requester waits at most NUM_REQ-1 grants.
//  grant_id holds its value after release until the next grant.
//  Counter widths: clog2 of their limit. The burst count never exceeds MAX_BURST.
// STRUCTURE
//  uart_defs.vh: state encodings (IDLE=0, SEND=1, WAIT=2, GAP=3) and the default
//    CLKS_PER_BIT, shared with the rx/tx blocks.
//  Sub-module rr_arbiter: combinational pick of (req_valid, last_grant) ->
//    (found, winner_idx).
//  Top level holds the FSM, the gap/timeout/burst counters and the data mux.
// TESTING (NUM_REQ=4, GAP_CLKS=16, MAX_BURST=4, TIMEOUT_CLKS=200; model serializer
//   pulses tx_done 160 clocks after tx_start)
//  Single requester: req 2 sends 0xA5 with last=1.
//    -> tx_start 2 clocks later, tx_data=0xA5, req_ready[2] pulse.
//    -> grant released 17 clocks after tx_done.
//  Contention: req 0,1,3 each send one byte with last=1, all valid at once.
//    -> serialized in order 0,1,3; next round starts at the requester after 3, i.e. 0.
//  Burst limit: req 1 holds valid with a 6-byte packet 0x10..0x15, req 0 idle.
//    -> 0x10..0x13 sent; lock released; 0x14 sent under a fresh grant to req 1.
//  Preemption by burst: req 1 has 6 bytes, req 2 has 1 byte.
//    -> 4 bytes from req 1, then req 2, then the remaining 2 bytes from req 1.
//  Timeout: the serializer never asserts tx_done.
//    -> err_timeout pulse 200 clocks after tx_start; lock released; next requester served.
//  Reset mid-WAIT: reset low for 1 cycle.
//    -> all outputs at reset values next cycle; no req_ready; req 0 has priority afterwards.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_pkg
//  Description : Shared definitions for the UART transmit arbiter. Holds the
//                sequencer state encoding, the default bit period, and a
//                helper that sizes counters from their limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

    // Default UART bit period in clocks. It also sets the default inter-frame gap.
    localparam int c_DEFAULT_CLKS_PER_BIT = 1250;

    // Sequencer states. The encoding is shared with the rx/tx blocks.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    // Width of a counter that must reach (limit - 1). The result is never
    // less than 1, so a limit of 1 still produces a legal vector.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. It returns the first valid
//                requester after last_grant, wrapping at NUM_REQ.
//  Ports       : req_valid  - request vector
//                last_grant - index of the previous owner
//                found      - at least one requester is valid
//                winner_idx - selected requester (0 when found is low)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    last_grant,
    output logic               found,
    output logic [ID_W-1:0]    winner_idx
);

    int               w_pos;
    logic [ID_W-1:0]  w_cand;

    // The scan runs from the farthest position to the nearest one. Each later
    // hit overwrites the earlier one, so the nearest valid requester after
    // last_grant is the one that remains.
    always_comb begin
        found      = 1'b0;
        winner_idx = '0;
        w_pos      = 0;
        w_cand     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_pos  = (int'(last_grant) + k) % NUM_REQ;
            w_cand = ID_W'(w_pos);
            if (req_valid[w_cand]) begin
                found      = 1'b1;
                winner_idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmit serializer among NUM_REQ byte
//                streams. Ownership is granted round-robin and is held for one
//                packet or MAX_BURST bytes, whichever ends first. The block
//                drives the serializer over a tx_start/tx_done handshake,
//                inserts an inter-frame gap, and releases the lock when the
//                watchdog expires.
//  Ports       : clock, reset (synchronous, active-low)
//                req_valid/req_data/req_last in, req_ready out (1-cycle pulse)
//                tx_start/tx_data out, tx_done in (serializer handshake)
//                grant_id/grant_active out (lock status)
//                err_timeout out (1-cycle pulse on watchdog expiry)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT,
    parameter int GAP_CLKS     = CLKS_PER_BIT,
    parameter int MAX_BURST    = 4,
    parameter int TIMEOUT_CLKS = 15000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_active,
    output logic                       err_timeout
);

    localparam int c_ID_W    = $clog2(NUM_REQ);
    localparam int c_GAP_W   = cnt_width(GAP_CLKS);
    localparam int c_TMO_W   = cnt_width(TIMEOUT_CLKS);
    // The burst counter must be able to hold MAX_BURST itself.
    localparam int c_BURST_W = cnt_width(MAX_BURST + 1);

    arb_state_t           r_state;
    logic [c_ID_W-1:0]    r_last_grant;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic [c_TMO_W-1:0]   r_timer;
    logic [c_BURST_W-1:0] r_burst;
    logic                 r_lock_end;

    logic                 w_found;
    logic [c_ID_W-1:0]    w_winner;
    logic [7:0]           w_sel_data;
    logic                 w_sel_last;
    logic                 w_sel_valid;
    logic [c_BURST_W-1:0] w_burst_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (c_ID_W)
    ) u_rr_arbiter (
        .req_valid  (req_valid),
        .last_grant (r_last_grant),
        .found      (w_found),
        .winner_idx (w_winner)
    );

    // Route the current owner's lane.
    always_comb begin
        w_sel_data  = '0;
        w_sel_last  = 1'b0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == c_ID_W'(i)) begin
                w_sel_data  = req_data[8*i +: 8];
                w_sel_last  = req_last[i];
                w_sel_valid = req_valid[i];
            end
        end
    end

    assign w_burst_next = r_burst + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= c_ID_W'(NUM_REQ - 1);
            r_gap_cnt    <= '0;
            r_timer      <= '0;
            r_burst      <= '0;
            r_lock_end   <= 1'b0;
            req_ready    <= '0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            // Pulse outputs default low and are raised for exactly one cycle.
            req_ready   <= '0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        grant_id     <= w_winner;
                        grant_active <= 1'b1;
                        r_burst      <= '0;
                        r_state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_start   <= 1'b1;
                    tx_data    <= w_sel_data;
                    req_ready  <= NUM_REQ'(1) << grant_id;
                    r_burst    <= w_burst_next;
                    r_lock_end <= w_sel_last || (w_burst_next == c_BURST_W'(MAX_BURST));
                    r_timer    <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // tx_done is checked first, so it wins over an expiry in the same cycle.
                    if (tx_done) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end else if (r_timer == c_TMO_W'(TIMEOUT_CLKS - 1)) begin
                        err_timeout <= 1'b1;
                        r_lock_end  <= 1'b1;
                        r_gap_cnt   <= '0;
                        r_state     <= ST_GAP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == c_GAP_W'(GAP_CLKS - 1)) begin
                        // The owner keeps the lock only if it is still presenting data.
                        if (!r_lock_end && w_sel_valid) begin
                            r_state <= ST_SEND;
                        end else begin
                            r_last_grant <= grant_id;
                            grant_active <= 1'b0;
                            r_state      <= ST_IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter. Requester queues and
//                a serializer model drive the DUT. A transaction-level
//                round-robin model predicts the order of frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int GAP  = 16;
    localparam int MAXB = 4;
    localparam int TMO  = 200;
    localparam int SER  = 160;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_last  = '0;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done = 1'b0;
    logic [1:0]     grant_id;
    logic           grant_active;
    logic           err_timeout;

    typedef struct { int id; int data; int rdy; int cyc; } txrec_t;
    typedef struct { int id; int data; } exp_t;

    txrec_t     act[$];
    exp_t       expq[$];
    logic [8:0] pq [N][$];          // {last, data} per requester

    int compared = 0, mismatched = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0, release_cyc = 0, err_cyc = 0;
    int err_cnt = 0, grant_rises = 0, mute_left = 0;
    int model_last = N - 1, model_locks = 0;
    int valid_rise_cyc [N];
    bit ser_busy = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .CLKS_PER_BIT (GAP),
        .GAP_CLKS     (GAP),
        .MAX_BURST    (MAXB),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .err_timeout  (err_timeout)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Requester and serializer models, plus invariants checked on every frame.
    initial begin
        int rdy_idx;
        bit prev_ga, prev_err;
        logic [N-1:0] prev_valid;
        prev_ga = 0; prev_err = 0; prev_valid = '0;
        forever begin
            @(posedge clock); #1;
            cyc++;
            tx_done = 1'b0;
            rdy_idx = -1;
            for (int i = 0; i < N; i++) if (req_ready[i]) rdy_idx = i;
            if (tx_start || req_ready != '0) begin
                compared++;
                if (!(tx_start && $onehot(req_ready) && req_ready[grant_id])) begin
                    mismatched++;
                    $display("FAIL handshake: tx_start=%0b req_ready=%b grant_id=%0d, required one ready bit on the owner with tx_start", tx_start, req_ready, grant_id);
                end
            end
            if (tx_start) begin
                act.push_back('{int'(grant_id), int'(tx_data), rdy_idx, cyc});
                start_cyc = cyc;
                if (mute_left > 0) mute_left--;
                else ser_busy = 1'b1;
            end else if (ser_busy && cyc == start_cyc + SER) begin
                tx_done  = 1'b1;
                ser_busy = 1'b0;
                done_cyc = cyc;
            end
            if (err_timeout) begin
                err_cnt++;
                err_cyc = cyc;
                compared++;
                if (prev_err) begin
                    mismatched++;
                    $display("FAIL err_pulse: err_timeout high 2 cycles, required 1-cycle pulse");
                end
            end
            prev_err = err_timeout;
            if (grant_active && !prev_ga) grant_rises++;
            if (!grant_active && prev_ga) release_cyc = cyc;
            prev_ga = grant_active;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && pq[i].size() > 0) void'(pq[i].pop_front());
                req_valid[i]      = (pq[i].size() > 0);
                req_data[8*i +: 8] = req_valid[i] ? pq[i][0][7:0] : 8'h00;
                req_last[i]       = req_valid[i] ? pq[i][0][8] : 1'b0;
                if (req_valid[i] && !prev_valid[i]) valid_rise_cyc[i] = cyc;
            end
            prev_valid = req_valid;
        end
    end

    // Transaction-level prediction. Every requester with pending bytes competes.
    // An owner sends until its packet ends, MAX_BURST bytes have gone, or a
    // frame times out. The next owner is the nearest non-empty queue after the
    // previous owner.
    task automatic build_expected(input bit mute_first);
        logic [8:0] mq [N][$];
        logic [8:0] b;
        int o, burst;
        bit more, first, end_lock;
        for (int i = 0; i < N; i++) mq[i] = pq[i];
        expq.delete();
        model_locks = 0;
        first = 1'b1;
        more  = 1'b1;
        while (more) begin
            o = -1;
            for (int k = 1; k <= N; k++)
                if (o < 0 && mq[(model_last + k) % N].size() > 0) o = (model_last + k) % N;
            if (o < 0) more = 1'b0;
            else begin
                model_locks++;
                burst = 0;
                end_lock = 1'b0;
                while (!end_lock) begin
                    b = mq[o].pop_front();
                    expq.push_back('{o, int'(b[7:0])});
                    burst++;
                    end_lock = b[8] || (burst == MAXB) || (first && mute_first) || (mq[o].size() == 0);
                    first = 1'b0;
                end
                model_last = o;
            end
        end
    endtask

    task automatic wait_idle(input int n, output bit ok);
        int budget;
        budget = n * (TMO + GAP + 8) + 64;
        ok = 1'b0;
        while (budget > 0 && !ok) begin
            @(negedge clock);
            budget--;
            if (act.size() >= n && !grant_active) ok = 1'b1;
        end
        repeat (6) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        compared += 6;
        if (req_ready !== '0)     begin mismatched++; $display("FAIL reset_req_ready: got %b, required 0", req_ready); end
        if (tx_start !== 1'b0)    begin mismatched++; $display("FAIL reset_tx_start: got %0b, required 0", tx_start); end
        if (tx_data !== 8'h00)    begin mismatched++; $display("FAIL reset_tx_data: got %02h, required 00", tx_data); end
        if (grant_id !== 2'd0)    begin mismatched++; $display("FAIL reset_grant_id: got %0d, required 0", grant_id); end
        if (grant_active !== 1'b0) begin mismatched++; $display("FAIL reset_grant_active: got %0b, required 0", grant_active); end
        if (err_timeout !== 1'b0) begin mismatched++; $display("FAIL reset_err_timeout: got %0b, required 0", err_timeout); end
        reset = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    // Two rounds: 0,1,3 with one byte each, then 0 and 3 again. The second
    // round starts at requester 0 because the previous owner was 3.
    task automatic test_contention();
        int g0, e0; bit ok;
        act.delete(); g0 = grant_rises; e0 = err_cnt;
        @(negedge clock);
        pq[0].push_back({1'b1, 8'h01}); pq[0].push_back({1'b1, 8'h11});
        pq[1].push_back({1'b1, 8'h02});
        pq[3].push_back({1'b1, 8'h03}); pq[3].push_back({1'b1, 8'h13});
        build_expected(1'b0);
        wait_idle(expq.size(), ok);
        compared += 4;
        if (!ok) begin mismatched++; $display("FAIL contention_done: no idle within budget, got %0d frames", act.size()); end
        if (act.size() !== expq.size()) begin mismatched++; $display("FAIL contention_count: got %0d frames, required %0d", act.size(), expq.size()); end
        if (grant_rises - g0 !== model_locks) begin mismatched++; $display("FAIL contention_grants: got %0d, required %0d", grant_rises - g0, model_locks); end
        if (err_cnt !== e0) begin mismatched++; $display("FAIL contention_err: got %0d timeouts, required 0", err_cnt - e0); end
        for (int i = 0; i < expq.size() && i < act.size(); i++) begin
            compared++;
            if (act[i].id !== expq[i].id || act[i].data !== expq[i].data) begin
                mismatched++;
                $display("FAIL contention_frame%0d: got req %0d data %02h, required req %0d data %02h", i, act[i].id, act[i].data, expq[i].id, expq[i].data);
            end
        end
    endtask

    // Requester 1 has 6 bytes and requester 2 has 1 byte. The burst limit cuts
    // requester 1 after 4 bytes, requester 2 is served next, then requester 1 finishes.
    task automatic test_preempt();
        int g0; bit ok;
        act.delete(); g0 = grant_rises;
        @(negedge clock);
        for (int k = 0; k < 6; k++) pq[1].push_back({k == 5, 8'h20 + 8'(k)});
        pq[2].push_back({1'b1, 8'h30});
        build_expected(1'b0);
        wait_idle(expq.size(), ok);
        compared += 3;
        if (!ok) begin mismatched++; $display("FAIL preempt_done: no idle within budget, got %0d frames", act.size()); end
        if (act.size() !== expq.size()) begin mismatched++; $display("FAIL preempt_count: got %0d frames, required %0d", act.size(), expq.size()); end
        if (grant_rises - g0 !== model_locks) begin mismatched++; $display("FAIL preempt_grants: got %0d, required %0d", grant_rises - g0, model_locks); end
        for (int i = 0; i < expq.size() && i < act.size(); i++) begin
            compared++;
            if (act[i].id !== expq[i].id || act[i].data !== expq[i].data) begin
                mismatched++;
                $display("FAIL preempt_frame%0d: got req %0d data %02h, required req %0d data %02h", i, act[i].id, act[i].data, expq[i].id, expq[i].data);
            end
        end
    endtask

    task automatic test_burst_limit();
        int g0; bit ok;
        act.delete(); g0 = grant_rises;
        @(negedge clock);
        for (int k = 0; k < 6; k++) pq[1].push_back({k == 5, 8'h10 + 8'(k)});
        build_expected(1'b0);
        wait_idle(expq.size(), ok);
        compared += 3;
        if (!ok) begin mismatched++; $display("FAIL burst_done: no idle within budget, got %0d frames", act.size()); end
        if (act.size() !== expq.size()) begin mismatched++; $display("FAIL burst_count: got %0d frames, required %0d", act.size(), expq.size()); end
        if (grant_rises - g0 !== model_locks) begin mismatched++; $display("FAIL burst_grants: got %0d, required %0d", grant_rises - g0, model_locks); end
        for (int i = 0; i < expq.size() && i < act.size(); i++) begin
            compared++;
            if (act[i].id !== expq[i].id || act[i].data !== expq[i].data) begin
                mismatched++;
                $display("FAIL burst_frame%0d: got req %0d data %02h, required req %0d data %02h", i, act[i].id, act[i].data, expq[i].id, expq[i].data);
            end
        end
    endtask

    task automatic test_single();
        bit ok;
        act.delete();
        @(negedge clock);
        pq[2].push_back({1'b1, 8'hA5});
        build_expected(1'b0);
        wait_idle(1, ok);
        compared += 2;
        if (!ok) begin mismatched++; $display("FAIL single_done: no idle within budget"); end
        if (act.size() !== 1) begin mismatched++; $display("FAIL single_count: got %0d frames, required 1", act.size()); end
        if (act.size() >= 1) begin
            compared += 4;
            if (act[0].id !== 2 || act[0].data !== 8'hA5) begin mismatched++; $display("FAIL single_frame: got req %0d data %02h, required req 2 data a5", act[0].id, act[0].data); end
            if (act[0].rdy !== 2) begin mismatched++; $display("FAIL single_ready: got ready index %0d, required 2", act[0].rdy); end
            if (act[0].cyc - valid_rise_cyc[2] !== 2) begin mismatched++; $display("FAIL single_latency: got %0d clocks, required 2", act[0].cyc - valid_rise_cyc[2]); end
            if (release_cyc - done_cyc !== GAP + 1) begin mismatched++; $display("FAIL single_release: got %0d clocks after tx_done, required %0d", release_cyc - done_cyc, GAP + 1); end
        end
    endtask

    // The serializer ignores the first frame. The watchdog releases requester 1,
    // requester 2 is served, then requester 1 sends its remaining byte.
    task automatic test_timeout();
        int e0; bit ok;
        act.delete(); e0 = err_cnt;
        @(negedge clock);
        mute_left = 1;
        pq[1].push_back({1'b0, 8'h40}); pq[1].push_back({1'b1, 8'h41});
        pq[2].push_back({1'b1, 8'h50});
        build_expected(1'b1);
        wait_idle(expq.size(), ok);
        compared += 3;
        if (!ok) begin mismatched++; $display("FAIL timeout_done: no idle within budget, got %0d frames", act.size()); end
        if (act.size() !== expq.size()) begin mismatched++; $display("FAIL timeout_count: got %0d frames, required %0d", act.size(), expq.size()); end
        if (err_cnt - e0 !== 1) begin mismatched++; $display("FAIL timeout_errs: got %0d pulses, required 1", err_cnt - e0); end
        if (act.size() >= 1) begin
            compared++;
            if (err_cyc - act[0].cyc !== TMO) begin mismatched++; $display("FAIL timeout_delay: got %0d clocks, required %0d", err_cyc - act[0].cyc, TMO); end
        end
        for (int i = 0; i < expq.size() && i < act.size(); i++) begin
            compared++;
            if (act[i].id !== expq[i].id || act[i].data !== expq[i].data) begin
                mismatched++;
                $display("FAIL timeout_frame%0d: got req %0d data %02h, required req %0d data %02h", i, act[i].id, act[i].data, expq[i].id, expq[i].data);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int budget; bit ok;
        act.delete();
        @(negedge clock);
        pq[2].push_back({1'b1, 8'h66});
        budget = 50;
        while (budget > 0 && act.size() == 0) begin @(negedge clock); budget--; end
        compared++;
        if (act.size() == 0) begin mismatched++; $display("FAIL midreset_start: got no tx_start, required one"); end
        repeat (20) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < N; i++) pq[i].delete();
        ser_busy = 1'b0;
        @(negedge clock);
        compared++;
        if ({req_ready, tx_start, tx_data, grant_id, grant_active, err_timeout} !== '0) begin
            mismatched++;
            $display("FAIL midreset_outputs: got ready=%b start=%0b data=%02h id=%0d active=%0b err=%0b, required all 0", req_ready, tx_start, tx_data, grant_id, grant_active, err_timeout);
        end
        reset = 1'b1;
        model_last = N - 1;
        act.delete();
        repeat (2) @(negedge clock);
        pq[3].push_back({1'b1, 8'h77});
        pq[0].push_back({1'b1, 8'h78});
        build_expected(1'b0);
        wait_idle(expq.size(), ok);
        compared += 2;
        if (!ok) begin mismatched++; $display("FAIL midreset_done: no idle within budget, got %0d frames", act.size()); end
        if (act.size() !== expq.size()) begin mismatched++; $display("FAIL midreset_count: got %0d frames, required %0d", act.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < act.size(); i++) begin
            compared++;
            if (act[i].id !== expq[i].id || act[i].data !== expq[i].data) begin
                mismatched++;
                $display("FAIL midreset_frame%0d: got req %0d data %02h, required req %0d data %02h", i, act[i].id, act[i].data, expq[i].id, expq[i].data);
            end
        end
    endtask

    task automatic test_random();
        int g0, e0, npk, len, total; bit ok;
        for (int r = 0; r < 3; r++) begin
            act.delete(); g0 = grant_rises; e0 = err_cnt; total = 0;
            @(negedge clock);
            for (int i = 0; i < N; i++) begin
                npk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2)) : 0;
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 6);
                    for (int k = 0; k < len; k++) begin
                        pq[i].push_back({k == len - 1, 8'($urandom_range(0, 255))});
                        total++;
                    end
                end
            end
            if (total == 0) pq[$urandom_range(0, N - 1)].push_back({1'b1, 8'h5A});
            build_expected(1'b0);
            wait_idle(expq.size(), ok);
            compared += 4;
            if (!ok) begin mismatched++; $display("FAIL random%0d_done: no idle within budget, got %0d frames", r, act.size()); end
            if (act.size() !== expq.size()) begin mismatched++; $display("FAIL random%0d_count: got %0d frames, required %0d", r, act.size(), expq.size()); end
            if (grant_rises - g0 !== model_locks) begin mismatched++; $display("FAIL random%0d_grants: got %0d, required %0d", r, grant_rises - g0, model_locks); end
            if (err_cnt !== e0) begin mismatched++; $display("FAIL random%0d_err: got %0d timeouts, required 0", r, err_cnt - e0); end
            for (int i = 0; i < expq.size() && i < act.size(); i++) begin
                compared++;
                if (act[i].id !== expq[i].id || act[i].data !== expq[i].data) begin
                    mismatched++;
                    $display("FAIL random%0d_frame%0d: got req %0d data %02h, required req %0d data %02h", r, i, act[i].id, act[i].data, expq[i].id, expq[i].data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_preempt();
        test_burst_limit();
        test_single();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
